// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_pkg
// Brief   : Shared state encodings, default timing constants and helpers for
//           the board reset sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_PLL_WAIT   = 3'd1,
    ST_STABLE     = 3'd2,
    ST_SDRAM_INIT = 3'd3,
    ST_CPU_HOLD   = 3'd4,
    ST_RUN        = 3'd5
  } seq_state_t;

  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 240;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 24000;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 4;
  localparam int unsigned DEF_INIT_TIMEOUT       = 48000;
  localparam int unsigned DEF_CPU_RST_CYCLES     = 12;

  typedef struct packed {
    logic pll;
    logic sdram;
    logic sys;
    logic cpu;
  } rst_vec_t;

  // Reset level of each domain while the sequencer sits in a given state.
  function automatic rst_vec_t rst_for_state(input seq_state_t s);
    rst_vec_t v;
    case (s)
      ST_PLL_RST:    v = '{pll: 1'b1, sdram: 1'b1, sys: 1'b1, cpu: 1'b1};
      ST_PLL_WAIT,
      ST_STABLE:     v = '{pll: 1'b0, sdram: 1'b1, sys: 1'b1, cpu: 1'b1};
      ST_SDRAM_INIT: v = '{pll: 1'b0, sdram: 1'b0, sys: 1'b1, cpu: 1'b1};
      ST_CPU_HOLD:   v = '{pll: 1'b0, sdram: 1'b0, sys: 1'b0, cpu: 1'b1};
      ST_RUN:        v = '{pll: 1'b0, sdram: 1'b0, sys: 1'b0, cpu: 1'b0};
      default:       v = '{pll: 1'b1, sdram: 1'b1, sys: 1'b1, cpu: 1'b1};
    endcase
    return v;
  endfunction

  // Bits needed to hold the largest of the cycle constants.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d,
                                            input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return unsigned'($clog2(m + 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq_if
// Brief   : Status inputs and reset/status outputs of the reset sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface reset_seq_if;

  logic       pll_locked;
  logic       sdram_init_done;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       sdram_rst;
  logic       sys_rst;
  logic       cpu_rst;
  logic [2:0] state;
  logic       err_init_timeout;
  logic       lock_lost;
  logic [7:0] relock_count;

  modport master (
    input  pll_locked, sdram_init_done, sw_rst_req,
    output pll_rst, sdram_rst, sys_rst, cpu_rst,
    output state, err_init_timeout, lock_lost, relock_count
  );

  modport slave (
    output pll_locked, sdram_init_done, sw_rst_req,
    input  pll_rst, sdram_rst, sys_rst, cpu_rst,
    input  state, err_init_timeout, lock_lost, relock_count
  );

endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Two-flop level synchronizer, cleared by synchronous reset.
// Rev     : 1.0  initial release
// ============================================================================
module sync2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq
// Brief   : Board reset sequencer: PLL reset/lock, SDRAM init, system and CPU
//           release, with lock supervision and software CPU reset.
// Rev     : 1.0  initial release
// ============================================================================
module reset_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned INIT_TIMEOUT       = DEF_INIT_TIMEOUT,
  parameter int unsigned CPU_RST_CYCLES     = DEF_CPU_RST_CYCLES
) (
  input  wire logic    clk24_ref,
  input  wire logic    rst,
  reset_seq_if.master  bus
);

  localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, LOCK_TIMEOUT,
                                            PLL_RST_CYCLES, INIT_TIMEOUT,
                                            CPU_RST_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;

  logic locked_s;
  logic init_s;
  logic swreq_s;

  sync2 u_sync_lock  (.clk(clk24_ref), .rst(rst), .d(bus.pll_locked),      .q(locked_s));
  sync2 u_sync_init  (.clk(clk24_ref), .rst(rst), .d(bus.sdram_init_done), .q(init_s));
  sync2 u_sync_swreq (.clk(clk24_ref), .rst(rst), .d(bus.sw_rst_req),      .q(swreq_s));

  seq_state_t state_q,      state_d;
  cnt_t       cnt_q,        cnt_d;
  rst_vec_t   rst_q,        rst_d;
  logic       swreq_prev_q, swreq_prev_d;
  logic       err_init_q,   err_init_d;
  logic       lock_lost_q,  lock_lost_d;
  logic [7:0] relock_q,     relock_d;

  logic sw_edge;
  logic cnt_last;

  // Each timed state lasts exactly its load value: leave when count reads 1.
  function automatic cnt_t load_for(input seq_state_t s);
    case (s)
      ST_PLL_RST:    return cnt_t'(PLL_RST_CYCLES);
      ST_PLL_WAIT:   return cnt_t'(LOCK_TIMEOUT);
      ST_STABLE:     return cnt_t'(LOCK_STABLE_CYCLES);
      ST_SDRAM_INIT: return cnt_t'(INIT_TIMEOUT);
      ST_CPU_HOLD:   return cnt_t'(CPU_RST_CYCLES);
      default:       return cnt_t'(1);
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    err_init_d   = err_init_q;
    lock_lost_d  = lock_lost_q;
    relock_d     = relock_q;
    swreq_prev_d = swreq_s;
    sw_edge      = swreq_s & ~swreq_prev_q;
    cnt_last     = (cnt_q == cnt_t'(1));

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_last) state_d = ST_PLL_WAIT;
      end
      ST_PLL_WAIT: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_last) begin
          state_d = ST_PLL_RST;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      ST_STABLE: begin
        if (!locked_s)     state_d = ST_PLL_WAIT;
        else if (cnt_last) state_d = ST_SDRAM_INIT;
      end
      // Lock loss outranks every other exit in the released states.
      ST_SDRAM_INIT: begin
        if (!locked_s) begin
          state_d     = ST_PLL_WAIT;
          lock_lost_d = 1'b1;
        end else if (init_s) begin
          state_d = ST_CPU_HOLD;
        end else if (cnt_last) begin
          state_d    = ST_STABLE;
          err_init_d = 1'b1;
        end
      end
      ST_CPU_HOLD: begin
        if (!locked_s) begin
          state_d     = ST_PLL_WAIT;
          lock_lost_d = 1'b1;
        end else if (cnt_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_PLL_WAIT;
          lock_lost_d = 1'b1;
        end else if (sw_edge) begin
          state_d = ST_CPU_HOLD;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    if (state_d != state_q) cnt_d = load_for(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - cnt_t'(1);
    else                    cnt_d = cnt_q;

    // Outputs are decoded from the next state so they flop with the state.
    rst_d = rst_for_state(state_d);
  end

  always_ff @(posedge clk24_ref) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= cnt_t'(PLL_RST_CYCLES);
      rst_q        <= '{pll: 1'b1, sdram: 1'b1, sys: 1'b1, cpu: 1'b1};
      swreq_prev_q <= 1'b0;
      err_init_q   <= 1'b0;
      lock_lost_q  <= 1'b0;
      relock_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_q        <= rst_d;
      swreq_prev_q <= swreq_prev_d;
      err_init_q   <= err_init_d;
      lock_lost_q  <= lock_lost_d;
      relock_q     <= relock_d;
    end
  end

  assign bus.pll_rst          = rst_q.pll;
  assign bus.sdram_rst        = rst_q.sdram;
  assign bus.sys_rst          = rst_q.sys;
  assign bus.cpu_rst          = rst_q.cpu;
  assign bus.state            = state_q;
  assign bus.err_init_timeout = err_init_q;
  assign bus.lock_lost        = lock_lost_q;
  assign bus.relock_count     = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_seq
// Brief   : Self-checking bench for reset_seq with short timing parameters.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reset_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reset_seq_if bus ();

  reset_seq #(
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (32),
    .PLL_RST_CYCLES    (4),
    .INIT_TIMEOUT      (16),
    .CPU_RST_CYCLES    (6)
  ) dut (
    .clk24_ref(clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int         n;
    logic       r;
    logic       lk;
    logic       ini;
    logic       sw;
    logic [2:0] st;
    logic [3:0] rv;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rvec();
    return int'({bus.pll_rst, bus.sdram_rst, bus.sys_rst, bus.cpu_rst});
  endfunction

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int n = 0;
    while (bus.state != s && n < bound) begin
      tick();
      n++;
    end
    chk(name, int'(bus.state), int'(s));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_vec", rvec(), 15);
    chk("rst_err", int'(bus.err_init_timeout), 0);
    chk("rst_lost", int'(bus.lock_lost), 0);
    chk("rst_relock", int'(bus.relock_count), 0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, hi, bad;
    logic seen_low;

    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.sdram_init_done = 1'b0;
    bus.sw_rst_req = 1'b0;

    // {cycles, rst, lock, init, swreq, state, {pll,sdram,sys,cpu}}
    tbl[0]  = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111};
    tbl[1]  = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111};
    tbl[2]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0111};
    tbl[3]  = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0111};
    tbl[4]  = '{8, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0111};
    tbl[5]  = '{6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0011};
    tbl[6]  = '{2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'b0011};
    tbl[7]  = '{6, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 4'b0001};
    tbl[8]  = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4'b0000};
    tbl[9]  = '{2, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 4'b0000};
    tbl[10] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 4'b0001};
    tbl[11] = '{5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 4'b0001};
    tbl[12] = '{2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4'b0000};

    // Normal boot followed by a 3-cycle software reset pulse.
    for (int i = 0; i < 13; i++) begin
      rst                 = tbl[i].r;
      bus.pll_locked      = tbl[i].lk;
      bus.sdram_init_done = tbl[i].ini;
      bus.sw_rst_req      = tbl[i].sw;
      for (int c = 0; c < tbl[i].n; c++) begin
        tick();
        chk($sformatf("row%0d_c%0d_state", i, c), int'(bus.state), int'(tbl[i].st));
        chk($sformatf("row%0d_c%0d_rst", i, c), rvec(), int'(tbl[i].rv));
      end
    end
    chk("boot_err", int'(bus.err_init_timeout), 0);
    chk("boot_lost", int'(bus.lock_lost), 0);

    // Lock loss in RUN coincident with a software request edge.
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b1;
    tick();
    tick();
    chk("ll_pre_state", int'(bus.state), 5);
    chk("ll_pre_rst", rvec(), 0);
    chk("ll_pre_lost", int'(bus.lock_lost), 0);
    tick();
    chk("ll_state", int'(bus.state), 1);
    chk("ll_rst", rvec(), 7);
    chk("ll_lost", int'(bus.lock_lost), 1);
    bus.pll_locked = 1'b1;
    wait_state(3'd5, 80, "ll_reboot");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.state != 3'd5 || bus.cpu_rst != 1'b0) bad++;
    end
    chk("ll_sw_not_queued", bad, 0);
    chk("ll_lost_sticky", int'(bus.lock_lost), 1);
    bus.sw_rst_req = 1'b0;

    // Reset from RUN clears the sticky flags.
    apply_reset();

    // Lock glitch during STABLE, then an SDRAM init timeout.
    bus.pll_locked = 1'b1;
    bus.sdram_init_done = 1'b0;
    wait_state(3'd2, 40, "gl_reach_stable");
    repeat (4) tick();
    bus.pll_locked = 1'b0;
    tick();
    chk("gl_s1", int'(bus.state), 2);
    tick();
    chk("gl_s2", int'(bus.state), 2);
    tick();
    chk("gl_wait", int'(bus.state), 1);
    chk("gl_sdram", int'(bus.sdram_rst), 1);
    bus.pll_locked = 1'b1;
    tick();
    tick();
    chk("gl_wait2", int'(bus.state), 1);
    tick();
    chk("gl_restable", int'(bus.state), 2);
    n = 0;
    bad = 0;
    while (bus.state == 3'd2 && n < 50) begin
      n++;
      if (!bus.sdram_rst) bad++;
      tick();
    end
    chk("gl_stable_len", n, 8);
    chk("gl_sdram_held", bad, 0);
    chk("gl_to_init", int'(bus.state), 3);

    chk("it_err_before", int'(bus.err_init_timeout), 0);
    n = 0;
    while (bus.state == 3'd3 && n < 100) begin
      n++;
      tick();
    end
    chk("it_len", n, 16);
    chk("it_state", int'(bus.state), 2);
    chk("it_err", int'(bus.err_init_timeout), 1);
    n = 0;
    bad = 0;
    while (bus.state == 3'd2 && n < 100) begin
      n++;
      if (!bus.sdram_rst) bad++;
      tick();
    end
    chk("it_sdram_len", n, 8);
    chk("it_sdram_high", bad, 0);
    bus.sdram_init_done = 1'b1;
    wait_state(3'd5, 60, "it_boot");
    chk("it_err_sticky", int'(bus.err_init_timeout), 1);

    apply_reset();

    // Lock never arrives: periodic PLL reset and relock counting.
    bus.pll_locked = 1'b0;
    bus.sdram_init_done = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      hi = 1;
      seen_low = 1'b0;
      n = 0;
      while (n < 200) begin
        tick();
        n++;
        if (!bus.pll_rst) seen_low = 1'b1;
        else if (!seen_low) hi++;
        else break;
      end
      chk($sformatf("to%0d_period", k), n, 36);
      chk($sformatf("to%0d_pll_hi", k), hi, 4);
      chk($sformatf("to%0d_state", k), int'(bus.state), 0);
      chk($sformatf("to%0d_count", k), int'(bus.relock_count), k);
    end
    n = 0;
    while (bus.relock_count != 8'd255 && n < 12000) begin
      tick();
      n++;
    end
    chk("sat_reach", int'(bus.relock_count), 255);
    repeat (80) tick();
    chk("sat_hold", int'(bus.relock_count), 255);

    apply_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
